// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter; 1-clk accept-to-start, then self-timed frame hold-off.
// Backpressure: ready is offered only in IDLE, so requesters hold valid for up to FRAME_CLKS+2 clks per frame.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int CLKS_PER_BIT = 868,
    parameter int FRAME_BITS   = 10,
    parameter int GUARD_CLKS   = 0,
    parameter int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_start,
    output logic                 o_busy,
    output logic [ID_W-1:0]      o_grant_id,
    output logic [15:0]          o_bytes_sent
);
    localparam int FRAME_CLKS = FRAME_BITS * CLKS_PER_BIT + GUARD_CLKS;
    localparam int CNT_W      = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  win;
    logic [ID_W-1:0]  scan;
    logic [7:0]       win_dat;
    logic             found;
    logic             accept;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        win   = '0;
        scan  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            scan = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && i_req_valid[scan]) begin
                found = 1'b1;
                win   = scan;
            end
        end
    end

    always_comb begin
        win_dat = 8'h00;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win == ID_W'(k)) win_dat = i_req_data[8*k +: 8];
        end
    end

    assign accept = (state == IDLE) && found;
    assign o_busy = (state != IDLE);

    always_comb begin
        o_req_ready = '0;
        if (accept) o_req_ready[win] = 1'b1;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = START;
            START:   state_next = WAIT;
            WAIT:    if (cnt == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt          <= '0;
            ptr          <= ID_W'(NUM_REQ - 1);
            o_tx_data    <= 8'h00;
            o_tx_start   <= 1'b0;
            o_grant_id   <= '0;
            o_bytes_sent <= 16'h0000;
        end else begin
            // Start pulse is high exactly while the FSM sits in START.
            o_tx_start <= accept;
            if (accept) begin
                o_tx_data    <= win_dat;
                o_grant_id   <= win;
                ptr          <= win;
                o_bytes_sent <= o_bytes_sent + 16'd1;
            end
            if (state == START)
                cnt <= CNT_W'(FRAME_CLKS - 1);
            else if (state == WAIT && cnt != '0)
                cnt <= cnt - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a 42-clock frame (4 clks/bit, 10 bits, 2 guard clks).
module tb_uart_tx_arbiter;
    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        busy;
    logic [0:0]  grant_id;
    logic [15:0] bytes_sent;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .NUM_REQ(2), .CLKS_PER_BIT(4), .FRAME_BITS(10), .GUARD_CLKS(2)
    ) dut (
        .clk(clk), .i_reset(rst_n),
        .i_req_valid(req_valid), .i_req_data(req_data), .o_req_ready(req_ready),
        .o_tx_data(tx_data), .o_tx_start(tx_start), .o_busy(busy),
        .o_grant_id(grant_id), .o_bytes_sent(bytes_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_timeout: busy=%b after %0d cycles, want 0", busy, n); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 2'b00; req_data = 16'h0000;
        #12;
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (tx_data !== 8'h00)      begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        checks++; if (tx_start !== 1'b0)      begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        checks++; if (grant_id !== 1'b0)      begin errors++; $display("FAIL reset_grant: got %b want 0", grant_id); end
        checks++; if (bytes_sent !== 16'h0)   begin errors++; $display("FAIL reset_bytes: got %h want 0000", bytes_sent); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (req_ready !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle: ready=%b busy=%b want 00/0", req_ready, busy); end
    endtask

    task automatic test_single();
        int n, starts;
        req_data = 16'h0041; req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b00;
        checks++; if (tx_start !== 1'b1)     begin errors++; $display("FAIL single_start: got %b want 1", tx_start); end
        checks++; if (tx_data !== 8'h41)     begin errors++; $display("FAIL single_data: got %h want 41", tx_data); end
        checks++; if (bytes_sent !== 16'd1)  begin errors++; $display("FAIL single_bytes: got %0d want 1", bytes_sent); end
        checks++; if (grant_id !== 1'b0)     begin errors++; $display("FAIL single_grant: got %b want 0", grant_id); end
        n = 0; starts = 0;
        while (busy && n < 100) begin
            n++;
            if (tx_start) starts++;
            tick();
        end
        checks++; if (n != 43)          begin errors++; $display("FAIL single_busy_len: got %0d want 43", n); end
        checks++; if (starts != 1)      begin errors++; $display("FAIL single_start_count: got %0d want 1", starts); end
        checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL single_data_hold: got %h want 41", tx_data); end
    endtask

    task automatic test_contention();
        logic [7:0] sd [4];
        logic       sg [4];
        int         se [4];
        int         got, e, multi;
        rst_n = 1'b0; req_valid = 2'b11; req_data = 16'h2211;
        #2;
        tick();
        rst_n = 1'b1;
        got = 0; e = 0; multi = 0;
        while (got < 4 && e < 300) begin
            tick();
            e++;
            if ($countones(req_ready) > 1) multi++;
            if (tx_start) begin
                sd[got] = tx_data; sg[got] = grant_id[0]; se[got] = e;
                got++;
            end
        end
        req_valid = 2'b00;
        checks++; if (got != 4)   begin errors++; $display("FAIL cont_count: got %0d want 4", got); end
        checks++; if (multi != 0) begin errors++; $display("FAIL cont_onehot: %0d cycles with >1 ready, want 0", multi); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sd[i] !== ((i % 2) ? 8'h22 : 8'h11) || sg[i] !== ((i % 2) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL cont_order[%0d]: data=%h grant=%b want %h/%0d", i, sd[i], sg[i], (i % 2) ? 8'h22 : 8'h11, i % 2);
            end
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (se[i] - se[i-1] != 44) begin errors++; $display("FAIL cont_spacing[%0d]: got %0d want 44", i, se[i] - se[i-1]); end
        end
        wait_idle();
    endtask

    task automatic test_busy_request();
        int e, first_rdy, start_e, rdy_in_busy;
        req_data = 16'h2211; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        e = 0; first_rdy = -1; start_e = -1; rdy_in_busy = 0;
        while (start_e < 0 && e < 200) begin
            tick();
            e++;
            if (e == 5) req_valid = 2'b10;
            #1;
            if (busy && req_ready != 2'b00) rdy_in_busy++;
            if (req_ready != 2'b00 && first_rdy < 0) first_rdy = e;
            if (tx_start) begin
                start_e = e;
                req_valid = 2'b00;
            end
        end
        checks++; if (rdy_in_busy != 0) begin errors++; $display("FAIL busy_no_ready: %0d ready cycles while busy, want 0", rdy_in_busy); end
        checks++; if (first_rdy != 43)  begin errors++; $display("FAIL busy_first_ready: got %0d want 43", first_rdy); end
        checks++; if (start_e != 44)    begin errors++; $display("FAIL busy_accept_spacing: got %0d want 44", start_e); end
        checks++; if (tx_data !== 8'h22 || grant_id !== 1'b1) begin errors++; $display("FAIL busy_req1: data=%h grant=%b want 22/1", tx_data, grant_id); end
    endtask

    task automatic test_withdrawn();
        int starts, readies;
        starts = 0; readies = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 3)  req_valid = 2'b01;
            if (i == 13) req_valid = 2'b00;
            #1;
            if (i > 1 && tx_start) starts++;
            if (req_ready != 2'b00) readies++;
        end
        checks++; if (starts != 0)          begin errors++; $display("FAIL withdraw_start: got %0d pulses want 0", starts); end
        checks++; if (readies != 0)         begin errors++; $display("FAIL withdraw_ready: got %0d want 0", readies); end
        checks++; if (bytes_sent !== 16'd6) begin errors++; $display("FAIL withdraw_bytes: got %0d want 6", bytes_sent); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL withdraw_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        req_data = 16'h5A33; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        repeat (21) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (tx_data !== 8'h00)    begin errors++; $display("FAIL midrst_data: got %h want 00", tx_data); end
        checks++; if (bytes_sent !== 16'd0) begin errors++; $display("FAIL midrst_bytes: got %0d want 0", bytes_sent); end
        req_valid = 2'b10;
        #1;
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL midrst_ready: got %b want 10", req_ready); end
        tick();
        req_valid = 2'b00;
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h5A) begin errors++; $display("FAIL midrst_accept: start=%b data=%h want 1/5a", tx_start, tx_data); end
        checks++; if (grant_id !== 1'b1 || bytes_sent !== 16'd1) begin errors++; $display("FAIL midrst_grant: grant=%b bytes=%0d want 1/1", grant_id, bytes_sent); end
        wait_idle();
    endtask

    task automatic test_wrap();
        force dut.o_bytes_sent = 16'hFFFE;
        #1;
        release dut.o_bytes_sent;
        #1;
        checks++; if (bytes_sent !== 16'hFFFE) begin errors++; $display("FAIL wrap_preload: got %h want fffe", bytes_sent); end
        req_data = 16'h0077; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        checks++; if (bytes_sent !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %h want ffff", bytes_sent); end
        wait_idle();
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        checks++; if (bytes_sent !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h want 0000", bytes_sent); end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_busy_request();
        test_withdrawn();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
